// File: rtl/branch_cmp_seq.sv
// Multi-cycle branch-resolution sequencer.
// Latches a branch request and forms the compare operand on a shared zero-detect
// unit. It then resolves one of six branch conditions from the zero flag and the
// operand sign, and reports taken / err / pc_next with a one-cycle done pulse.
module branch_cmp_seq #(
    parameter int W     = 32,
    parameter int OFS_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [W-1:0]     rs_val,
    input  logic [W-1:0]     rt_val,
    input  logic [W-1:0]     pc_plus4,
    input  logic [OFS_W-1:0] offset,
    output logic [W-1:0]     zd_a,
    input  logic             zd_o,
    output logic             busy,
    output logic             done,
    output logic             taken,
    output logic             err,
    output logic [W-1:0]     pc_next
);

    // Branch opcodes; 6 and 7 are illegal.
    localparam logic [2:0] OP_BEQ  = 3'd0;
    localparam logic [2:0] OP_BNE  = 3'd1;
    localparam logic [2:0] OP_BLEZ = 3'd2;
    localparam logic [2:0] OP_BGTZ = 3'd3;
    localparam logic [2:0] OP_BLTZ = 3'd4;
    localparam logic [2:0] OP_BGEZ = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_EVAL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic [W-1:0]     rs_q;
    logic [W-1:0]     rt_q;
    logic [W-1:0]     pc4_q;
    logic [OFS_W-1:0] ofs_q;
    logic [W-1:0]     tgt_q;

    // Byte offset of the branch target: sign-extended immediate, word-scaled.
    logic [W-1:0] ofs_bytes;
    // Operand the zero-detect unit should see for the latched op.
    logic [W-1:0] operand;
    // Condition decoded from the zero-detect result and operand sign.
    logic         dec_taken;
    logic         dec_err;
    logic         flag_z;
    logic         flag_n;

    // Immediate sign extension and scaling for the target adder.
    always_comb begin
        ofs_bytes = {{(W-OFS_W){ofs_q[OFS_W-1]}}, ofs_q} << 2;
    end

    // Equality branches compare via the difference; the rest test rs alone.
    always_comb begin
        operand = rs_q;
        if (op_q == OP_BEQ || op_q == OP_BNE) begin
            operand = rs_q - rt_q;
        end
    end

    // Branch condition table evaluated from Z (all-zero operand) and N (sign).
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves
        // it unassigned and no latch is inferred.
        dec_taken = 1'b0;
        dec_err   = 1'b0;
        flag_z    = zd_o;
        flag_n    = zd_a[W-1];
        case (op_q)
            OP_BEQ:  dec_taken = flag_z;
            OP_BNE:  dec_taken = !flag_z;
            OP_BLEZ: dec_taken = flag_n | flag_z;
            OP_BGTZ: dec_taken = !flag_n & !flag_z;
            OP_BLTZ: dec_taken = flag_n;
            OP_BGEZ: dec_taken = !flag_n;
            default: dec_err   = 1'b1;
        endcase
    end

    // Sequencer FSM with registered handshake, zero-detect operand and results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register here is a plain flop, so all of them are reset
            // explicitly and an aborted operation leaves nothing stale behind.
            state   <= S_IDLE;
            op_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            pc4_q   <= '0;
            ofs_q   <= '0;
            tgt_q   <= '0;
            zd_a    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            taken   <= 1'b0;
            err     <= 1'b0;
            pc_next <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register samples
            // pre-edge values regardless of statement order.
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q  <= op;
                        rs_q  <= rs_val;
                        rt_q  <= rt_val;
                        pc4_q <= pc_plus4;
                        ofs_q <= offset;
                        busy  <= 1'b1;
                        state <= S_SUB;
                    end
                end
                S_SUB: begin
                    zd_a  <= operand;
                    tgt_q <= pc4_q + ofs_bytes;
                    state <= S_EVAL;
                end
                S_EVAL: begin
                    taken   <= dec_taken;
                    err     <= dec_err;
                    pc_next <= dec_taken ? tgt_q : pc4_q;
                    done    <= 1'b1;
                    state   <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
